// File: rtl/cdc_app_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdc_app_pkg : character constants and per-byte echo transform      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cdc_app_pkg;

  localparam logic [7:0] CHR_A_UC    = 8'h41;
  localparam logic [7:0] CHR_Z_UC    = 8'h5A;
  localparam logic [7:0] CHR_0       = 8'h30;
  localparam logic [7:0] CHR_8       = 8'h38;
  localparam logic [7:0] CHR_9       = 8'h39;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  // Uppercase folds to lowercase; digits rotate up by one, '9' wrapping to '0'.
  function automatic logic [7:0] xform_byte(input logic [7:0] b, input logic en);
    logic [7:0] r;
    r = b;
    if (en) begin
      if (b >= CHR_A_UC && b <= CHR_Z_UC)
        r = b + CASE_OFFSET;
      else if (b >= CHR_0 && b <= CHR_8)
        r = b + 8'd1;
      else if (b == CHR_9)
        r = CHR_0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_app_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdc_app_fifo : DEPTH-1 entry byte FIFO, sync write, head readable   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cdc_app_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam logic [AW-1:0] c_last_addr = AW'(ENTRIES - 1);

  logic [7:0]    r_mem [ENTRIES];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  // Slot count is not a power of two: wrap the address by hand and flip the extra bit.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[AW-1:0] == c_last_addr)
      return {~p[AW], {AW{1'b0}}};
    return p + PW'(1);
  endfunction

  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_i)
      r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i) !(push_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i) !(pop_i && empty_o));

endmodule
`default_nettype wire

// File: rtl/cdc_echo_app.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdc_echo_app : USB CDC echo stage - buffer, transform, return bytes |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cdc_echo_app
  import cdc_app_pkg::*;
#(
  parameter int   DEPTH         = 16,
  parameter logic XFORM_DEFAULT = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [7:0]               out_data_i,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  output logic [7:0]               in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  input  logic                     xform_set_i,
  input  logic                     xform_val_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     activity_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] c_full_level = LW'(DEPTH);

  logic          r_xform_en;
  logic          r_out_ready;
  logic          r_in_valid;
  logic [7:0]    r_in_data;
  logic [LW-1:0] r_level;
  logic          r_activity;

  logic          w_push;
  logic          w_pop;
  logic          w_slot_free;
  logic [7:0]    w_xdata;
  logic          w_ram_push;
  logic          w_ram_pop;
  logic [7:0]    w_ram_data;
  logic          w_ram_full;
  logic          w_ram_empty;
  logic [LW-1:0] w_level_nxt;

  assign w_push      = out_valid_i & r_out_ready;
  assign w_pop       = r_in_valid & in_ready_i;
  assign w_slot_free = ~r_in_valid | in_ready_i;
  assign w_xdata     = xform_byte(out_data_i, r_xform_en);

  // The output register only bypasses the RAM when the RAM holds nothing older.
  assign w_ram_pop  = w_slot_free & ~w_ram_empty;
  assign w_ram_push = w_push & ~(w_slot_free & w_ram_empty);

  cdc_app_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_ram_push),
    .wdata_i (w_xdata),
    .pop_i   (w_ram_pop),
    .rdata_o (w_ram_data),
    .full_o  (w_ram_full),
    .empty_o (w_ram_empty)
  );

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_xform_en  <= XFORM_DEFAULT;
      r_out_ready <= 1'b0;
      r_in_valid  <= 1'b0;
      r_in_data   <= 8'h00;
      r_level     <= '0;
      r_activity  <= 1'b0;
    end else begin
      if (xform_set_i)
        r_xform_en <= xform_val_i;
      r_level     <= w_level_nxt;
      // Registered from the next level so a pop while full never admits a same-cycle push.
      r_out_ready <= (w_level_nxt != c_full_level);
      if (w_push)
        r_activity <= ~r_activity;
      if (w_slot_free) begin
        if (!w_ram_empty) begin
          r_in_valid <= 1'b1;
          r_in_data  <= w_ram_data;
        end else if (w_push) begin
          r_in_valid <= 1'b1;
          r_in_data  <= w_xdata;
        end else begin
          r_in_valid <= 1'b0;
        end
      end
    end
  end

  assign out_ready_o = r_out_ready;
  assign in_valid_o  = r_in_valid;
  assign in_data_o   = r_in_data;
  assign level_o     = r_level;
  assign activity_o  = r_activity;

  a_push_when_ready: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(w_push && !out_ready_o));
  a_level_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (r_level <= c_full_level) && !(w_ram_full && !r_in_valid));

endmodule
`default_nettype wire

// File: doc/cdc_echo_app.md
Name: cdc_echo_app

Overview:
- Application-side stage inside soc, directly downstream of u_usb_cdc's bulk OUT byte stream and directly upstream of its bulk IN byte stream.
- Buffers host-to-device bytes in a FIFO, applies a fixed per-byte character transform, and returns the bytes to the host on the IN endpoint.
- Backpressure on the OUT side makes usb_cdc NAK OUT packets when the buffer is full.
- An empty buffer makes usb_cdc NAK IN tokens.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of 2, >= 4.
- XFORM_DEFAULT, 1, value of xform_en after reset.

Ports:
- clk_i  input  1  system clock, same clock as usb_cdc application side
- rstn_i  input  1  synchronous active-low reset
- out_data_i  input  8  byte from usb_cdc OUT endpoint
- out_valid_i  input  1  out_data_i valid
- out_ready_o  output  1  block accepts byte; transfer when out_valid_i & out_ready_o at rising edge
- in_data_o  output  8  byte to usb_cdc IN endpoint
- in_valid_o  output  1  in_data_o valid
- in_ready_i  input  1  usb_cdc takes byte; transfer when in_valid_o & in_ready_i
- xform_set_i  input  1  one-cycle pulse: load xform_en from xform_val_i
- xform_val_i  input  1  new transform enable value
- level_o  output  $clog2(DEPTH)+1  bytes held, including the output register
- activity_o  output  1  toggles on every accepted OUT byte (drives led)

Behaviour:
- Reset: interface and state.
  - Clocking and reset: one clock. Reset is synchronous and active-low, sampled on the rising edge of clk_i.
  - Reset values: in_valid_o=0, in_data_o=8'h00, level_o=0, activity_o=0, xform_en=XFORM_DEFAULT, FIFO pointers=0.
  - out_ready_o=0 while rstn_i=0; it goes to 1 in the first cycle after reset release.
- Reset mid-operation: flushes all buffered bytes with no output glitch beyond the reset values. A byte handshaken in the same cycle as reset is dropped.
- Transform: applied at write, combinational on out_data_i, when xform_en=1.
  - 'A'..'Z' (8'h41..8'h5A) -> +8'h20 (lowercase).
  - '0'..'8' (8'h30..8'h38) -> +1.
  - '9' -> '0'.
  - All other bytes pass unchanged.
  - With xform_en=0, every byte passes unchanged.
- Transform timing: xform_set_i takes effect for bytes accepted from the next cycle on. Bytes already stored are not re-transformed.
- Storage: DEPTH-1 entries of RAM, plus a one-entry output register (in_data_o/in_valid_o). Total capacity is DEPTH.
- State: output register EMPTY/FULL, derived from in_valid_o. RAM uses read/write pointers one bit wider than the address, for full/empty detection.
- Write (OUT side):
  - out_ready_o = (level_o != DEPTH). Registered-equivalent: it depends only on state, never combinationally on out_valid_i or in_ready_i.
  - When full, a simultaneous pop does not allow a same-cycle push. out_ready_o rises the cycle after the pop.
- Read (IN side):
  - If the output register is empty or being popped (in_ready_i=1), it loads from the RAM head if the RAM is non-empty.
  - Otherwise, if a byte is being written this cycle, it loads directly from the transformed out_data_i (bypass).
  - Otherwise in_valid_o goes to 0.
- Latency: a byte accepted at edge N into an empty block is valid on in_data_o after edge N (visible in cycle N+1). Sustained throughput is 1 byte/cycle each way.
- Ordering: strict FIFO, no reordering across the bypass path.
- Output stability: in_data_o is stable while in_valid_o=1 & in_ready_i=0.
- Level: level_o changes +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop. It never exceeds DEPTH and never underflows.
- Pointers: wrap modulo DEPTH-1 RAM slots via the extra-bit compare. Overflow and underflow are impossible by construction; an assertion fires if a push occurs with out_ready_o=0.

Decomposition:
- Package cdc_app_pkg:
  - character constants CHR_A_UC, CHR_Z_UC, CHR_0, CHR_8, CHR_9, CASE_OFFSET = 8'h20
  - function xform_byte(byte, en)
- Sub-module: cdc_app_fifo, a DEPTH-1 entry synchronous RAM FIFO with push/pop/full/empty.
- The top level owns the output register, bypass, transform and level counter.

Test Plan:
- Reset → out_ready_o=1 one cycle after release, in_valid_o=0, level_o=0.
- Push 8'h01..8'h07 with in_ready_i=1 → in_data_o sequence 01..07, each valid one cycle after its push, level_o back to 0.
- Push "12345678" then "ABCDEFGH", xform on → pop returns "23456789" then "abcdefgh". Repeat with xform off → bytes unchanged. Byte '9' → '0'.
- in_ready_i=0, push 20 bytes → out_ready_o drops after 16th accept, level_o=16. Release in_ready_i for 1 cycle → out_ready_o=1 next cycle; the 17th byte is accepted and ordering is preserved.
- Simultaneous push/pop at level 5 for 10 cycles → level_o stays 5, no byte lost or duplicated. Random valid/ready for 10k bytes → scoreboard matches. activity_o toggles 10k times.
- Assert rstn_i=0 at level 9 mid-stream → next cycle in_valid_o=0, level_o=0. Subsequent traffic starts fresh with correct data.
